// File: rtl/max_search_2d_roi.sv
// max_search_2d_roi: raster-scans a run-time ROI of a stored image and reports the max/min value and its position
module max_search_2d_roi #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int COLS = 12,
  parameter int ROWS = 3,
  parameter int XW = 4,
  parameter int YW = 2,
  parameter int ROW_STRIDE = 50
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          We,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] D,
  input  logic          En,
  input  logic          Mode,
  input  logic [XW-1:0] XStart,
  input  logic [YW-1:0] YStart,
  input  logic [XW:0]   XLen,
  input  logic [YW:0]   YLen,
  output logic [DW-1:0] MaxValue,
  output logic [XW-1:0] MaxXPos,
  output logic [YW-1:0] MaxYPos,
  output logic          MaxValid,
  output logic          RangeErr,
  output logic          Busy,
  output logic [XW-1:0] XIndex_out,
  output logic [YW-1:0] YIndex_out
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data, best_val, nxt_val;
  logic [XW-1:0] x, x_start, x_end, rd_x, best_x, nxt_x;
  logic [YW-1:0] y, y_end, rd_y, best_y, nxt_y;
  logic [XW+1:0] x_sum;
  logic [YW+1:0] y_sum;
  logic [AW-1:0] addr;
  logic accept, legal, last, mode, first, rd_vld, take;
  assign accept = En && (state == IDLE || state == DONE);
  assign x_sum = (XW+2)'(XStart) + (XW+2)'(XLen);
  assign y_sum = (YW+2)'(YStart) + (YW+2)'(YLen);
  assign legal = XLen != '0 && YLen != '0 && x_sum <= (XW+2)'(COLS) && y_sum <= (YW+2)'(ROWS);
  assign last = x == x_end && y == y_end;
  assign addr = AW'(y) * AW'(ROW_STRIDE) + AW'(x);
  assign Busy = state == SCAN || state == DRAIN;
  assign XIndex_out = state == SCAN ? x : '0;
  assign YIndex_out = state == SCAN ? y : '0;
  // The first datum of a run loads unconditionally; strict compare keeps the earliest tie
  assign take = first || (mode ? rd_data < best_val : rd_data > best_val);
  assign nxt_val = take ? rd_data : best_val;
  assign nxt_x = take ? rd_x : best_x;
  assign nxt_y = take ? rd_y : best_y;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? (legal ? SCAN : DONE) :
                (state == SCAN && last) ? DRAIN :
                state == DRAIN ? DONE : state;
  end
  always_ff @(posedge Clk) begin
    if (We) mem[WA] <= D;
    rd_data <= mem[addr];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      {x, y, x_start, x_end, y_end, mode, first, rd_vld, rd_x, rd_y} <= '0;
      {best_val, best_x, best_y} <= '0;
      {MaxValue, MaxXPos, MaxYPos, MaxValid, RangeErr} <= '0;
    end else begin
      state <= state_nxt;
      rd_vld <= state == SCAN;
      rd_x <= x;
      rd_y <= y;
      if (rd_vld) begin
        best_val <= nxt_val;
        best_x <= nxt_x;
        best_y <= nxt_y;
        first <= 1'b0;
      end
      if (accept) begin
        mode <= Mode;
        x <= XStart;
        y <= YStart;
        x_start <= XStart;
        x_end <= XW'(x_sum - 1'b1);
        y_end <= YW'(y_sum - 1'b1);
        first <= 1'b1;
        MaxValid <= !legal;
        if (!legal) {MaxValue, MaxXPos, MaxYPos, RangeErr} <= {{(DW+XW+YW){1'b0}}, 1'b1};
      end else if (state == SCAN) begin
        x <= x == x_end ? x_start : x + 1'b1;
        y <= x == x_end ? y + 1'b1 : y;
      end else if (state == DRAIN) begin
        MaxValid <= 1'b1;
        RangeErr <= 1'b0;
        MaxValue <= nxt_val;
        MaxXPos <= nxt_x;
        MaxYPos <= nxt_y;
      end
    end
  end
endmodule
